// File: rtl/exe_alu_md_if.sv
// Operand, sideband and valid/ready handshake bus of the exe_alu_md execute stage.
// The slave modport is the stage itself; the master modport is the ID_EXE / EXE_WB side.
interface exe_alu_md_if #(
    parameter int XLEN       = 32,
    parameter int GPR_ADDR_W = 5,
    parameter int OP_W       = 5
) ();
    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [OP_W-1:0]       op_i;
    logic                  use_imm_i;
    logic [XLEN-1:0]       rs1_val_i;
    logic [XLEN-1:0]       rs2_val_i;
    logic [XLEN-1:0]       imm_i;
    logic [GPR_ADDR_W-1:0] rd_addr_i;
    logic                  rd_we_i;
    logic                  mem_re_i;
    logic                  mem_we_i;
    logic [XLEN-1:0]       fwd1_val_i;
    logic                  fwd1_rs1_i;
    logic                  fwd1_rs2_i;
    logic [XLEN-1:0]       fwd2_val_i;
    logic                  fwd2_rs1_i;
    logic                  fwd2_rs2_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [XLEN-1:0]       alu_val_o;
    logic [XLEN-1:0]       rs2_val_o;
    logic [GPR_ADDR_W-1:0] rd_addr_o;
    logic                  rd_we_o;
    logic                  mem_re_o;
    logic                  mem_we_o;

    modport slave (
        input  flush_i, in_valid_i, op_i, use_imm_i, rs1_val_i, rs2_val_i, imm_i,
               rd_addr_i, rd_we_i, mem_re_i, mem_we_i,
               fwd1_val_i, fwd1_rs1_i, fwd1_rs2_i, fwd2_val_i, fwd2_rs1_i, fwd2_rs2_i,
               out_ready_i,
        output in_ready_o, out_valid_o, alu_val_o, rs2_val_o,
               rd_addr_o, rd_we_o, mem_re_o, mem_we_o
    );

    modport master (
        output flush_i, in_valid_i, op_i, use_imm_i, rs1_val_i, rs2_val_i, imm_i,
               rd_addr_i, rd_we_i, mem_re_i, mem_we_i,
               fwd1_val_i, fwd1_rs1_i, fwd1_rs2_i, fwd2_val_i, fwd2_rs1_i, fwd2_rs2_i,
               out_ready_i,
        input  in_ready_o, out_valid_o, alu_val_o, rs2_val_o,
               rd_addr_o, rd_we_o, mem_re_o, mem_we_o
    );
endinterface

// File: rtl/exe_alu_md.sv
// Execute stage: RV32I/RV64I ALU ops plus M-extension multiply/divide with radix-2 iteration.
// Define EXE_FAST_MUL_EN for a single-cycle multiplier; divide always stays iterative.
module exe_alu_md #(
    parameter int XLEN       = 32,
    parameter int GPR_ADDR_W = 5,
    parameter int OP_W       = 5
) (
    input logic        clk,
    input logic        rst,
    exe_alu_md_if.slave bus
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(5'd0);
    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(5'd1);
    localparam logic [OP_W-1:0] OP_SLT    = OP_W'(5'd2);
    localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(5'd3);
    localparam logic [OP_W-1:0] OP_XOR    = OP_W'(5'd4);
    localparam logic [OP_W-1:0] OP_OR     = OP_W'(5'd5);
    localparam logic [OP_W-1:0] OP_AND    = OP_W'(5'd6);
    localparam logic [OP_W-1:0] OP_SLL    = OP_W'(5'd7);
    localparam logic [OP_W-1:0] OP_SRL    = OP_W'(5'd8);
    localparam logic [OP_W-1:0] OP_SRA    = OP_W'(5'd9);
    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(5'd10);
    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(5'd11);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(5'd12);
    localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(5'd13);
    localparam logic [OP_W-1:0] OP_DIV    = OP_W'(5'd14);
    localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(5'd15);
    localparam logic [OP_W-1:0] OP_REM    = OP_W'(5'd16);
    localparam logic [OP_W-1:0] OP_REMU   = OP_W'(5'd17);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  mul_r, neg_r, hi_sel_r;
    logic [XLEN-1:0]       hi_r, lo_r, dvs_r;
    logic                  out_valid_r;
    logic [XLEN-1:0]       alu_val_r, rs2_val_r;
    logic [GPR_ADDR_W-1:0] rd_addr_r;
    logic                  rd_we_r, mem_re_r, mem_we_r;

    logic [OP_W-1:0]       op_s;
    logic [XLEN-1:0]       op_a_s, rs2_fwd_s, op_b_s, mag_a_s, mag_b_s, quick_s;
    logic                  is_mul_s, is_div_s, is_rem_s, a_neg_s, b_neg_s, neg_s, hi_sel_s;
    logic                  div_zero_s, div_ovf_s, single_s, in_ready_s, accept_s;
    logic [XLEN:0]         mul_sum_s, div_shift_s, div_diff_s;
    logic [XLEN-1:0]       next_hi_s, next_lo_s, div_sel_s, final_s;
    logic [2*XLEN-1:0]     prod_raw_s, prod_fix_s;
`ifdef EXE_FAST_MUL_EN
    logic [2*XLEN-1:0]     fast_prod_s, fast_fix_s;
`endif

    assign op_s       = bus.op_i;
    assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready_i);
    assign accept_s   = bus.in_valid_i && in_ready_s;

    // Operand forwarding: the nearest producer wins, then the older one, then the register file
    always_comb begin
        if (bus.fwd1_rs1_i)      op_a_s = bus.fwd1_val_i;
        else if (bus.fwd2_rs1_i) op_a_s = bus.fwd2_val_i;
        else                     op_a_s = bus.rs1_val_i;
        if (bus.fwd1_rs2_i)      rs2_fwd_s = bus.fwd1_val_i;
        else if (bus.fwd2_rs2_i) rs2_fwd_s = bus.fwd2_val_i;
        else                     rs2_fwd_s = bus.rs2_val_i;
        if (bus.use_imm_i)       op_b_s = bus.imm_i;
        else                     op_b_s = rs2_fwd_s;
    end

    // Op classification, operand magnitudes and result sign for multiply/divide
    always_comb begin
        is_mul_s   = (op_s >= OP_MUL) && (op_s <= OP_MULHU);
        is_div_s   = (op_s >= OP_DIV) && (op_s <= OP_REMU);
        is_rem_s   = (op_s == OP_REM) || (op_s == OP_REMU);
        a_neg_s    = op_a_s[XLEN-1] && ((op_s == OP_MUL) || (op_s == OP_MULH) || (op_s == OP_MULHSU)
                                        || (op_s == OP_DIV) || (op_s == OP_REM));
        b_neg_s    = op_b_s[XLEN-1] && ((op_s == OP_MUL) || (op_s == OP_MULH)
                                        || (op_s == OP_DIV) || (op_s == OP_REM));
        mag_a_s    = a_neg_s ? -op_a_s : op_a_s;
        mag_b_s    = b_neg_s ? -op_b_s : op_b_s;
        neg_s      = (is_div_s && is_rem_s) ? a_neg_s : (a_neg_s ^ b_neg_s);
        hi_sel_s   = is_mul_s ? (op_s != OP_MUL) : is_rem_s;
        div_zero_s = (op_b_s == {XLEN{1'b0}});
        div_ovf_s  = ((op_s == OP_DIV) || (op_s == OP_REM))
                     && (op_a_s == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_s == {XLEN{1'b1}});
`ifdef EXE_FAST_MUL_EN
        single_s   = !is_div_s || div_zero_s || div_ovf_s;
`else
        single_s   = !(is_mul_s || is_div_s) || (is_div_s && (div_zero_s || div_ovf_s));
`endif
    end

`ifdef EXE_FAST_MUL_EN
    // Full-width product of the magnitudes, sign fixed afterwards like the iterative path
    always_comb begin
        fast_prod_s = {{XLEN{1'b0}}, mag_a_s} * {{XLEN{1'b0}}, mag_b_s};
        fast_fix_s  = neg_s ? -fast_prod_s : fast_prod_s;
    end
`endif

    // Single-cycle results, including the divide corner cases caught at accept
    always_comb begin
        case (op_s)
            OP_ADD:  quick_s = op_a_s + op_b_s;
            OP_SUB:  quick_s = op_a_s - op_b_s;
            OP_SLT:  quick_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            OP_SLTU: quick_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            OP_XOR:  quick_s = op_a_s ^ op_b_s;
            OP_OR:   quick_s = op_a_s | op_b_s;
            OP_AND:  quick_s = op_a_s & op_b_s;
            OP_SLL:  quick_s = op_a_s << op_b_s[SH_W-1:0];
            OP_SRL:  quick_s = op_a_s >> op_b_s[SH_W-1:0];
            OP_SRA:  quick_s = $signed(op_a_s) >>> op_b_s[SH_W-1:0];
            OP_DIV, OP_DIVU: quick_s = div_zero_s ? {XLEN{1'b1}} : op_a_s;
            OP_REM, OP_REMU: quick_s = div_zero_s ? op_a_s : {XLEN{1'b0}};
`ifdef EXE_FAST_MUL_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU:
                     quick_s = hi_sel_s ? fast_fix_s[2*XLEN-1:XLEN] : fast_fix_s[XLEN-1:0];
`endif
            default: quick_s = {XLEN{1'b0}};
        endcase
    end

    // One radix-2 step: shift-add multiply in {hi,lo}, or restoring divide with remainder in hi
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + {1'b0, (lo_r[0] ? dvs_r : {XLEN{1'b0}})};
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, dvs_r};
        if (mul_r) begin
            next_hi_s = mul_sum_s[XLEN:1];
            next_lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end else if (!div_diff_s[XLEN]) begin
            next_hi_s = div_diff_s[XLEN-1:0];
            next_lo_s = {lo_r[XLEN-2:0], 1'b1};
        end else begin
            next_hi_s = div_shift_s[XLEN-1:0];
            next_lo_s = {lo_r[XLEN-2:0], 1'b0};
        end
        prod_raw_s = {next_hi_s, next_lo_s};
        prod_fix_s = neg_r ? -prod_raw_s : prod_raw_s;
        div_sel_s  = hi_sel_r ? next_hi_s : next_lo_s;
        if (mul_r) final_s = hi_sel_r ? prod_fix_s[2*XLEN-1:XLEN] : prod_fix_s[XLEN-1:0];
        else       final_s = neg_r ? -div_sel_s : div_sel_s;
    end

    // Stage FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            mul_r       <= 1'b0;
            neg_r       <= 1'b0;
            hi_sel_r    <= 1'b0;
            hi_r        <= {XLEN{1'b0}};
            lo_r        <= {XLEN{1'b0}};
            dvs_r       <= {XLEN{1'b0}};
            out_valid_r <= 1'b0;
            alu_val_r   <= {XLEN{1'b0}};
            rs2_val_r   <= {XLEN{1'b0}};
            rd_addr_r   <= {GPR_ADDR_W{1'b0}};
            rd_we_r     <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
        end else if (bus.flush_i) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            rs2_val_r <= rs2_fwd_s;
            rd_addr_r <= bus.rd_addr_i;
            rd_we_r   <= bus.rd_we_i;
            mem_re_r  <= bus.mem_re_i;
            mem_we_r  <= bus.mem_we_i;
            cnt_r     <= {CNT_W{1'b0}};
            if (single_s) begin
                alu_val_r   <= quick_s;
                out_valid_r <= 1'b1;
                state_r     <= DONE;
            end else begin
                mul_r       <= is_mul_s;
                neg_r       <= neg_s;
                hi_sel_r    <= hi_sel_s;
                hi_r        <= {XLEN{1'b0}};
                lo_r        <= is_mul_s ? mag_b_s : mag_a_s;
                dvs_r       <= is_mul_s ? mag_a_s : mag_b_s;
                out_valid_r <= 1'b0;
                state_r     <= BUSY;
            end
        end else begin
            case (state_r)
                IDLE: out_valid_r <= 1'b0;
                BUSY: begin
                    hi_r  <= next_hi_s;
                    lo_r  <= next_lo_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        alu_val_r   <= final_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = out_valid_r;
    assign bus.alu_val_o   = alu_val_r;
    assign bus.rs2_val_o   = rs2_val_r;
    assign bus.rd_addr_o   = rd_addr_r;
    assign bus.rd_we_o     = rd_we_r;
    assign bus.mem_re_o    = mem_re_r;
    assign bus.mem_we_o    = mem_we_r;
endmodule

// File: tb/tb_exe_alu_md.sv
// Self-checking bench for exe_alu_md: randomized ops against an arithmetic reference model.
module tb_exe_alu_md;
    localparam int XLEN = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int OP_W = 5;
`ifdef EXE_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    exe_alu_md_if #(.XLEN(XLEN), .GPR_ADDR_W(GPR_ADDR_W), .OP_W(OP_W)) bus ();
    exe_alu_md #(.XLEN(XLEN), .GPR_ADDR_W(GPR_ADDR_W), .OP_W(OP_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        logic signed [31:0] a32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        a32 = a;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return (sa < sb) ? 32'd1 : 32'd0;
            3: return (a < b) ? 32'd1 : 32'd0;
            4: return a ^ b;
            5: return a | b;
            6: return a & b;
            7: return a << b[4:0];
            8: return a >> b[4:0];
            9: return a32 >>> b[4:0];
            10: begin p = sa * sb; return p[31:0]; end
            11: begin p = sa * sb; return p[63:32]; end
            12: begin p = sa * longint'(ub); return p[63:32]; end
            13: begin p = ua * ub; return p[63:32]; end
            14: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            16: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            17: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input int op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 10 && op <= 13) return MUL_LAT;
        if (op >= 14 && op <= 17) begin
            if (b == 32'd0) return 1;
            if ((op == 14 || op == 16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    task automatic idle_inputs();
        bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.op_i = '0; bus.use_imm_i = 1'b0;
        bus.rs1_val_i = '0; bus.rs2_val_i = '0; bus.imm_i = '0; bus.rd_addr_i = '0;
        bus.rd_we_i = 1'b0; bus.mem_re_i = 1'b0; bus.mem_we_i = 1'b0;
        bus.fwd1_val_i = '0; bus.fwd1_rs1_i = 1'b0; bus.fwd1_rs2_i = 1'b0;
        bus.fwd2_val_i = '0; bus.fwd2_rs1_i = 1'b0; bus.fwd2_rs2_i = 1'b0;
        bus.out_ready_i = 1'b1;
    endtask

    // Present one op with out_ready high, wait for its result and check everything it produces.
    task automatic run_op(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic use_imm,
                          input logic f1a, input logic f1b, input logic [31:0] f1v,
                          input logic f2a, input logic f2b, input logic [31:0] f2v, input string name);
        logic [31:0] a, r2, b, exp;
        logic [4:0] rd;
        logic we, re, mw;
        int exp_lat, lat;
        a  = f1a ? f1v : (f2a ? f2v : rs1);
        r2 = f1b ? f1v : (f2b ? f2v : rs2);
        b  = use_imm ? imm : r2;
        exp = ref_alu(op, a, b);
        exp_lat = ref_lat(op, a, b);
        rd = 5'($urandom); we = 1'($urandom); re = 1'($urandom); mw = 1'($urandom);
        @(negedge clk);
        bus.op_i = 5'(op); bus.rs1_val_i = rs1; bus.rs2_val_i = rs2; bus.imm_i = imm;
        bus.use_imm_i = use_imm; bus.fwd1_rs1_i = f1a; bus.fwd1_rs2_i = f1b; bus.fwd1_val_i = f1v;
        bus.fwd2_rs1_i = f2a; bus.fwd2_rs2_i = f2b; bus.fwd2_val_i = f2v;
        bus.rd_addr_i = rd; bus.rd_we_i = we; bus.mem_re_i = re; bus.mem_we_i = mw;
        bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1;
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++; $display("FAIL %s in_ready: got %b expected 1", name, bus.in_ready_o);
        end
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        lat = 1;
        while (bus.out_valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d (op %0d)", name, lat, exp_lat, op);
        end
        checks++;
        if (bus.alu_val_o !== exp) begin
            errors++; $display("FAIL %s result: op %0d a=%h b=%h got %h expected %h", name, op, a, b, bus.alu_val_o, exp);
        end
        checks++;
        if ({bus.rs2_val_o, bus.rd_addr_o, bus.rd_we_o, bus.mem_re_o, bus.mem_we_o} !== {r2, rd, we, re, mw}) begin
            errors++; $display("FAIL %s sideband: got %h/%h/%b%b%b expected %h/%h/%b%b%b", name,
                bus.rs2_val_o, bus.rd_addr_o, bus.rd_we_o, bus.mem_re_o, bus.mem_we_o, r2, rd, we, re, mw);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL %s drop: out_valid got %b expected 0", name, bus.out_valid_o);
        end
    endtask

    task automatic run_rr(input int op, input logic [31:0] a, input logic [31:0] b, input string name);
        run_op(op, a, b, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, name);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid_o, bus.alu_val_o, bus.rs2_val_o, bus.rd_addr_o, bus.rd_we_o, bus.mem_re_o, bus.mem_we_o} !== '0) begin
            errors++; $display("FAIL reset outputs: got %b/%h/%h/%h expected all zero",
                bus.out_valid_o, bus.alu_val_o, bus.rs2_val_o, bus.rd_addr_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready_o);
        end
    endtask

    task automatic test_add_imm();
        run_op(0, 32'd5, 32'd77, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "add_imm");
    endtask

    task automatic test_random_alu();
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 13);
            if (op > 9) op = $urandom_range(18, 31);
            run_op(op, $urandom, (i % 5 == 0) ? 32'($urandom_range(0, 40)) : $urandom, $urandom,
                   1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom, "rand_alu");
        end
    endtask

    task automatic test_forwarding();
        run_op(1, 32'd99, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 32'd10, 1'b1, 1'b0, 32'd20, "fwd_prio");
        run_op(1, 32'd99, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 32'd10, 1'b0, 1'b1, 32'd9, "fwd_rs2");
        run_op(4, 32'd1, 32'd2, 32'h1234, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hAA, "fwd_imm");
    endtask

    task automatic test_muldiv();
        run_rr(14, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_rr(16, 32'hFFFF_FFF9, 32'd2, "rem_neg");
        run_rr(15, 32'd1234, 32'd0, "divu_zero");
        run_rr(17, 32'd55, 32'd0, "remu_zero");
        run_rr(14, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_rr(16, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_rr(12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_rr(11, 32'h8000_0000, 32'h8000_0000, "mulh_min");
        for (int i = 0; i < 24; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(1, 9)) ^ {32{b[31]}};
            run_rr($urandom_range(10, 17), $urandom, b, "rand_md");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        bus.op_i = 5'd9; bus.rs1_val_i = 32'h8000_0000; bus.imm_i = 32'd4; bus.use_imm_i = 1'b1;
        bus.fwd1_rs1_i = 1'b0; bus.fwd1_rs2_i = 1'b0; bus.fwd2_rs1_i = 1'b0; bus.fwd2_rs2_i = 1'b0;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.alu_val_o !== 32'hF800_0000 || bus.in_ready_o !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got v=%b %h rdy=%b expected v=1 f8000000 rdy=1",
                bus.out_valid_o, bus.alu_val_o, bus.in_ready_o);
        end
        bus.op_i = 5'd3; bus.rs1_val_i = 32'd1; bus.rs2_val_i = 32'hFFFF_FFFF; bus.use_imm_i = 1'b0;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.alu_val_o !== 32'd1 || bus.in_ready_o !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got v=%b %h rdy=%b expected v=1 00000001 rdy=1",
                bus.out_valid_o, bus.alu_val_o, bus.in_ready_o);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: out_valid got %b expected 0", bus.out_valid_o);
        end
    endtask

    task automatic test_stall();
        int lat;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        bus.op_i = 5'd12; bus.rs1_val_i = 32'hFFFF_FFFF; bus.rs2_val_i = 32'hFFFF_FFFF; bus.use_imm_i = 1'b0;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        lat = 1;
        while (bus.out_valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== MUL_LAT) begin
            errors++; $display("FAIL stall latency: got %0d expected %0d", lat, MUL_LAT);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.alu_val_o !== 32'hFFFF_FFFF || bus.in_ready_o !== 1'b0) begin
                errors++; $display("FAIL stall hold %0d: got v=%b %h rdy=%b expected v=1 ffffffff rdy=0",
                    i, bus.out_valid_o, bus.alu_val_o, bus.in_ready_o);
            end
            @(posedge clk); #1;
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL stall release: out_valid got %b expected 0", bus.out_valid_o);
        end
    endtask

    task automatic test_flush();
        logic seen;
        @(negedge clk);
        bus.op_i = 5'd14; bus.rs1_val_i = 32'd100; bus.rs2_val_i = 32'd7; bus.use_imm_i = 1'b0;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            errors++; $display("FAIL flush state: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid_o, bus.in_ready_o);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL flush discard: late out_valid got %b expected 0", seen);
        end
        @(negedge clk);
        bus.op_i = 5'd0; bus.in_valid_i = 1'b1; bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0; bus.flush_i = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_accept: out_valid got %b expected 0", bus.out_valid_o);
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        bus.op_i = 5'd14; bus.rs1_val_i = 32'd500; bus.rs2_val_i = 32'd3; bus.use_imm_i = 1'b0;
        bus.rd_addr_i = 5'd7; bus.rd_we_i = 1'b1; bus.mem_re_i = 1'b1; bus.mem_we_i = 1'b1;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.out_valid_o, bus.alu_val_o, bus.rs2_val_o, bus.rd_addr_o, bus.rd_we_o, bus.mem_re_o, bus.mem_we_o} !== '0
            || bus.in_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got v=%b %h %h %h %b%b%b rdy=%b expected all zero rdy=1",
                bus.out_valid_o, bus.alu_val_o, bus.rs2_val_o, bus.rd_addr_o,
                bus.rd_we_o, bus.mem_re_o, bus.mem_we_o, bus.in_ready_o);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy ghost: out_valid got %b expected 0", bus.out_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_back_to_back();
        test_forwarding();
        test_random_alu();
        test_muldiv();
        test_stall();
        test_flush();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exe_alu_md.md
Name: exe_alu_md

Overview:
- Parametrised execute stage, successor to the single-cycle immediate-only EXE.
- Covers RV32I/RV64I register and immediate ALU ops plus the M extension (MUL/MULH/MULHSU/MULHU, DIV/DIVU, REM/REMU).
- Sits between ID_EXE and EXE_WB and has two-source operand forwarding.
- Uses a valid/ready handshake on both sides so multi-cycle multiply/divide can stall ID.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- GPR_ADDR_W, 5, register address width.
- OP_W, 5, width of op_i.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  kill in-flight and pending op
- in_valid_i  in  1  ID_EXE presents op
- in_ready_o  out  1  stage can accept op
- op_i  in  OP_W  operation code (encoding below)
- use_imm_i  in  1  operand B = imm_i instead of rs2
- rs1_val_i, rs2_val_i  in  XLEN  register operands
- imm_i  in  XLEN  sign-extended immediate
- rd_addr_i  in  GPR_ADDR_W  destination register
- rd_we_i, mem_re_i, mem_we_i  in  1  sideband passed through to EXE_WB
- fwd1_val_i  in  XLEN  forward value from EXE_WB (nearest)
- fwd1_rs1_i, fwd1_rs2_i  in  1  apply fwd1 to rs1 / rs2
- fwd2_val_i  in  XLEN  forward value from WB (older)
- fwd2_rs1_i, fwd2_rs2_i  in  1  apply fwd2 to rs1 / rs2
- out_valid_o  out  1  result valid
- out_ready_i  in  1  EXE_WB accepts result
- alu_val_o  out  XLEN  result
- rs2_val_o  out  XLEN  forwarded rs2 (store data)
- rd_addr_o  out  GPR_ADDR_W; rd_we_o, mem_re_o, mem_we_o  out  1  registered sideband

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: out_valid_o=0, alu_val_o=0, rs2_val_o=0, rd_addr_o=0, rd_we_o=0, mem_re_o=0, mem_we_o=0, FSM=IDLE, iteration counter=0.
- Forwarding (combinational, per operand, independent for rs1 and rs2):
  - fwd1 has priority over fwd2, which has priority over the register value.
  - Operand B = imm_i when use_imm_i=1, otherwise the forwarded rs2.
  - rs2_val_o always captures the forwarded rs2.
- Op encoding:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - Any other code gives result 0 with latency 1.
- Shifts: amount = B[4:0] when XLEN=32, B[5:0] when XLEN=64.
- SLT/SLTU: signed/unsigned compare; result is 1 or 0, zero-extended.
- FSM states IDLE, BUSY, DONE; in_ready_o=1 only in IDLE, or in DONE when out_ready_i=1.
- IDLE:
  - Accept on in_valid_i & in_ready_o.
  - Ops 0–9 and unknown codes: result and sideband registered at that edge, go to DONE (latency 1).
  - Ops 10–17: latch operands and signs, counter=0, go to BUSY.
- BUSY:
  - Radix-2 iteration, one bit per cycle.
  - Multiply is shift-add on magnitudes with a final sign fix; divide is restoring division on magnitudes with a final sign fix.
  - After XLEN iterations, write the result and go to DONE. Latency is XLEN+1 cycles from accept to out_valid_o.
- DONE:
  - out_valid_o=1; outputs held stable until out_ready_i=1.
  - On the handshake, accept a new op in the same cycle if in_valid_i=1 (back-to-back), otherwise return to IDLE with out_valid_o=0.
- Divide corner cases, both detected at accept and producing latency 1:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (most-negative / -1): DIV gives the dividend; REM gives 0.
- MULH variants return the upper XLEN bits of the 2·XLEN product. MUL returns the lower XLEN bits.
- flush_i:
  - Highest priority after rst. Next state is IDLE and out_valid_o=0; the partial result is discarded.
  - An op presented in the same cycle as flush_i is not accepted.
- Sideband outputs are valid only while out_valid_o=1, but they hold their last value otherwise.

Optional Feature:
- Macro: EXE_FAST_MUL_EN.
- When defined: ops 10–13 use a single-cycle combinational 2·XLEN multiplier with latency 1 (IDLE→DONE); divide stays iterative.
- When undefined: multiply is iterative as described, with latency XLEN+1. The product bits and the handshake are identical in both builds.

Test Plan:
- Reset, then op=ADD, rs1=5, imm=-3, use_imm=1 → next cycle out_valid_o=1, alu_val_o=2; rd_addr/rd_we match the input.
- Back-to-back:
  - Stimulus: SRA rs1=0x80000000, B=4, followed by SLTU rs1=1, rs2=0xFFFFFFFF, with out_ready_i held at 1.
  - Response: consecutive results 0xF8000000 then 1; in_ready_o never drops.
- Forwarding: fwd1_rs1=1 (val 10) and fwd2_rs1=1 (val 20), SUB with rs2=3 → result 7. With fwd2_rs2=1 (val 9) → rs2_val_o=9.
- DIV -7/2 → -3 after 33 cycles; REM → -1. DIVU x/0 → 0xFFFFFFFF at latency 1. DIV 0x80000000/-1 → 0x80000000.
- MULHSU rs1=-1, rs2=0xFFFFFFFF → 0xFFFFFFFF.
  - Without EXE_FAST_MUL_EN: latency 33, and out_ready_i held 0 for 5 cycles keeps outputs stable.
  - With EXE_FAST_MUL_EN: latency 1.
- flush_i at BUSY cycle 10 of a DIV → out_valid_o stays 0, in_ready_o=1 next cycle. Reset mid-BUSY → all outputs 0.
